// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU for the MIPS datapath.
//  Single-cycle ops (AND/OR/ADD/SUB/SLT) finish one cycle after the start;
//  MULTU (shift-add) and DIVU (restoring) iterate LARGURA cycles over a
//  2*LARGURA accumulator. Operands/opcode are captured at start, results are
//  registered at FIM and held until the next FIM.
// Ports:
//  clk, reset (async, active-high), inicio (start, sampled only when idle)
//  ULAcontrole  opcode: 0000 AND 0001 OR 0010 ADD 0110 SUB 0111 SLT 1000 MULTU 1001 DIVU
//  SrcA, SrcB   operands (dividend / divisor for DIVU)
//  ULAsaida     result / product low / quotient
//  saida_hi     product high / remainder, 0 for single-cycle ops
//  overflow     signed overflow of ADD/SUB; zero: ULAsaida == 0
//  erro_div0    DIVU by zero; ocupado: op in progress; pronto: results just updated
module ula_multiciclo #(
  parameter int LARGURA = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inicio,
  input  logic [3:0]         ULAcontrole,
  input  logic [LARGURA-1:0] SrcA,
  input  logic [LARGURA-1:0] SrcB,
  output logic [LARGURA-1:0] ULAsaida,
  output logic [LARGURA-1:0] saida_hi,
  output logic               overflow,
  output logic               zero,
  output logic               erro_div0,
  output logic               ocupado,
  output logic               pronto
);
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam int CW = $clog2(LARGURA + 1);

  typedef enum logic [1:0] {OCIOSO, CALC, FIM} estado_t;
  estado_t estado, prox;

  logic [LARGURA-1:0]   a_q, b_q;
  logic [3:0]           op_q;
  logic [CW-1:0]        cont;
  logic [2*LARGURA-1:0] acc, acc_mul, acc_div;

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) estado <= OCIOSO;
    else       estado <= prox;

  // next state
  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO: if (inicio)
                prox = (ULAcontrole == OP_MULTU || ULAcontrole == OP_DIVU) ? CALC : FIM;
      CALC:   if (cont == CW'(1)) prox = FIM;
      FIM:    prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    ocupado = (estado != OCIOSO);
  end

  // MULTU step: acc = {partial high, remaining multiplier bits}; add A into
  // the high half when the current multiplier bit is set, then shift right.
  logic [LARGURA:0] soma_mul;
  always_comb begin
    soma_mul = {1'b0, acc[2*LARGURA-1:LARGURA]} + (acc[0] ? {1'b0, a_q} : '0);
    acc_mul  = {soma_mul, acc[LARGURA-1:1]};
  end

  // DIVU step: acc = {remainder, dividend bits shifting into quotient}.
  // With B==0 the compare always succeeds, so the quotient fills with ones and
  // the remainder ends up holding A with no special casing.
  logic [LARGURA:0]   t_div, dif_div;
  logic               ge_div;
  logic [LARGURA-1:0] rem_novo;
  always_comb begin
    t_div    = {acc[2*LARGURA-1:LARGURA], acc[LARGURA-1]};
    ge_div   = (t_div >= {1'b0, b_q});
    dif_div  = t_div - {1'b0, b_q};
    rem_novo = ge_div ? dif_div[LARGURA-1:0] : t_div[LARGURA-1:0];
    acc_div  = {rem_novo, acc[LARGURA-2:0], ge_div};
  end

  // result selection from the captured operands
  logic [LARGURA-1:0] soma, dif, res_lo, res_hi;
  logic               ovf_add, ovf_sub, res_ovf;
  always_comb begin
    soma    = a_q + b_q;
    dif     = a_q - b_q;
    ovf_add = (a_q[LARGURA-1] == b_q[LARGURA-1]) && (soma[LARGURA-1] != a_q[LARGURA-1]);
    ovf_sub = (a_q[LARGURA-1] != b_q[LARGURA-1]) && (dif[LARGURA-1] != a_q[LARGURA-1]);
    res_lo  = '0;
    res_hi  = '0;
    res_ovf = 1'b0;
    case (op_q)
      OP_AND:   res_lo = a_q & b_q;
      OP_OR:    res_lo = a_q | b_q;
      OP_ADD:   begin res_lo = soma; res_ovf = ovf_add; end
      OP_SUB:   begin res_lo = dif;  res_ovf = ovf_sub; end
      // sign XOR overflow keeps the signed compare right when A-B wraps
      OP_SLT:   res_lo = {{(LARGURA-1){1'b0}}, dif[LARGURA-1] ^ ovf_sub};
      OP_MULTU,
      OP_DIVU:  begin res_lo = acc[LARGURA-1:0]; res_hi = acc[2*LARGURA-1:LARGURA]; end
      default:  ;
    endcase
  end

  // datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cont      <= '0;
      acc       <= '0;
      ULAsaida  <= '0;
      saida_hi  <= '0;
      overflow  <= 1'b0;
      erro_div0 <= 1'b0;
      zero      <= 1'b1;
      pronto    <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: if (inicio) begin
          a_q  <= SrcA;
          b_q  <= SrcB;
          op_q <= ULAcontrole;
          cont <= CW'(LARGURA);
          acc  <= (ULAcontrole == OP_DIVU) ? {{LARGURA{1'b0}}, SrcA}
                                           : {{LARGURA{1'b0}}, SrcB};
        end
        CALC: begin
          cont <= cont - CW'(1);
          acc  <= (op_q == OP_MULTU) ? acc_mul : acc_div;
        end
        FIM: begin
          ULAsaida  <= res_lo;
          saida_hi  <= res_hi;
          overflow  <= res_ovf;
          erro_div0 <= (op_q == OP_DIVU) && (b_q == '0);
          zero      <= (res_lo == '0);
          pronto    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_multiciclo.sv
module tb_ula_multiciclo;
  logic        clk = 1'b0;
  logic        reset;
  logic        inicio, inicio8;
  logic [3:0]  ULAcontrole, ctl8;
  logic [31:0] SrcA, SrcB, ULAsaida, saida_hi;
  logic [7:0]  a8, b8, lo8, hi8;
  logic        overflow, zero, erro_div0, ocupado, pronto;
  logic        ovf8, zero8, e08, ocup8, pronto8;
  int          nchk = 0, nfail = 0;

  always #5 clk = ~clk;

  ula_multiciclo #(.LARGURA(32)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .ULAcontrole(ULAcontrole),
    .SrcA(SrcA), .SrcB(SrcB), .ULAsaida(ULAsaida), .saida_hi(saida_hi),
    .overflow(overflow), .zero(zero), .erro_div0(erro_div0),
    .ocupado(ocupado), .pronto(pronto));

  ula_multiciclo #(.LARGURA(8)) dut8 (
    .clk(clk), .reset(reset), .inicio(inicio8), .ULAcontrole(ctl8),
    .SrcA(a8), .SrcB(b8), .ULAsaida(lo8), .saida_hi(hi8),
    .overflow(ovf8), .zero(zero8), .erro_div0(e08),
    .ocupado(ocup8), .pronto(pronto8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: plain integer arithmetic on the spec rules
  function automatic void modelo(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] lo, output logic [31:0] hi,
                                 output logic ovf, output logic e0);
    longint sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = 0; hi = 0; ovf = 0; e0 = 0;
    case (op)
      4'b0000: lo = a & b;
      4'b0001: lo = a | b;
      4'b0010: begin r = sa + sb; lo = a + b; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b0110: begin r = sa - sb; lo = a - b; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b0111: lo = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: begin p = 64'(a) * 64'(b); lo = p[31:0]; hi = p[63:32]; end
      4'b1001: if (b == 0) begin lo = 32'hFFFFFFFF; hi = a; e0 = 1; end
               else begin lo = a / b; hi = a % b; end
      default: ;
    endcase
  endfunction

  // start an op, optionally re-pulse inicio mid-flight, and check the result
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input bit repulse);
    logic [31:0] elo, ehi;
    logic eovf, ee0;
    int lat, exp_lat;
    modelo(op, a, b, elo, ehi, eovf, ee0);
    exp_lat = (op == 4'b1000 || op == 4'b1001) ? 33 : 1;
    @(negedge clk);
    ULAcontrole = op; SrcA = a; SrcB = b; inicio = 1;
    @(posedge clk); #1;
    inicio = 0; SrcA = $urandom; SrcB = $urandom; ULAcontrole = 4'($urandom);
    chk("ocupado_after_start", 64'(ocupado), 64'd1);
    lat = 0;
    while (!pronto && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      inicio = (repulse && lat == 5);
    end
    inicio = 0;
    chk($sformatf("latency op=%b", op), 64'(lat), 64'(exp_lat));
    chk($sformatf("lo op=%b a=%h b=%h", op, a, b), 64'(ULAsaida), 64'(elo));
    chk($sformatf("hi op=%b a=%h b=%h", op, a, b), 64'(saida_hi), 64'(ehi));
    chk($sformatf("ovf op=%b", op), 64'(overflow), 64'(eovf));
    chk($sformatf("erro_div0 op=%b", op), 64'(erro_div0), 64'(ee0));
    chk($sformatf("zero op=%b", op), 64'(zero), 64'(elo == 0));
    @(posedge clk); #1;
    chk("pronto_one_cycle", 64'(pronto), 64'd0);
    chk("ocupado_idle", 64'(ocupado), 64'd0);
    chk("lo_held", 64'(ULAsaida), 64'(elo));
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] elo, input logic [7:0] ehi, input logic eovf, input int exp_lat);
    int lat;
    @(negedge clk);
    ctl8 = op; a8 = a; b8 = b; inicio8 = 1;
    @(posedge clk); #1;
    inicio8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!pronto8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("w8 latency op=%b", op), 64'(lat), 64'(exp_lat));
    chk($sformatf("w8 lo op=%b", op), 64'(lo8), 64'(elo));
    chk($sformatf("w8 hi op=%b", op), 64'(hi8), 64'(ehi));
    chk($sformatf("w8 ovf op=%b", op), 64'(ovf8), 64'(eovf));
  endtask

  initial begin
    logic [3:0] ops [9];
    logic [31:0] ra, rb;
    int q, r, np;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b0011, 4'b1111};
    reset = 1; inicio = 0; ULAcontrole = 0; SrcA = 0; SrcB = 0;
    inicio8 = 0; ctl8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ULAsaida", 64'(ULAsaida), 64'd0);
    chk("rst saida_hi", 64'(saida_hi), 64'd0);
    chk("rst overflow", 64'(overflow), 64'd0);
    chk("rst erro_div0", 64'(erro_div0), 64'd0);
    chk("rst zero", 64'(zero), 64'd1);
    chk("rst ocupado", 64'(ocupado), 64'd0);
    chk("rst pronto", 64'(pronto), 64'd0);
    @(negedge clk); reset = 0;

    // directed corner cases
    run(4'b0010, 32'h7FFFFFFF, 32'h00000001, 0);
    run(4'b0111, 32'h80000000, 32'h00000001, 0);
    run(4'b0110, 32'd5, 32'd5, 0);
    run(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run(4'b1001, 32'd100, 32'd7, 0);
    run(4'b1001, 32'd100, 32'd0, 0);
    run(4'b0000, 32'hF0F0F0F0, 32'h3C3C3C3C, 0);
    run(4'b0110, 32'h80000000, 32'h00000001, 0);
    run(4'b1000, 32'h12345678, 32'h9ABCDEF0, 1);
    run(4'b0011, 32'hDEADBEEF, 32'h1, 0);

    // random operations
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      run(ops[$urandom_range(0, 8)], ra, rb, 1'($urandom_range(0, 1)));
    end

    // narrow instance
    run8(4'b1000, 8'hFF, 8'hFF, 8'h01, 8'hFE, 0, 9);
    run8(4'b0010, 8'h7F, 8'h01, 8'h80, 8'h00, 1, 1);
    for (int i = 0; i < 4; i++) begin
      q = $urandom_range(1, 255);
      r = $urandom_range(0, 255);
      run8(4'b1001, 8'(r), 8'(q), 8'(r / q), 8'(r % q), 0, 9);
    end

    // reset in the middle of MULTU, with a re-pulsed inicio before it
    run(4'b0001, 32'h0000F00F, 32'h12000000, 0);
    @(negedge clk);
    ULAcontrole = 4'b1000; SrcA = 32'hFFFF0000; SrcB = 32'h00FF00FF; inicio = 1;
    @(posedge clk); #1;
    inicio = 0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
      inicio = (c == 5);
    end
    inicio = 0;
    chk("mid ocupado", 64'(ocupado), 64'd1);
    reset = 1; #1;
    chk("midrst ULAsaida", 64'(ULAsaida), 64'd0);
    chk("midrst saida_hi", 64'(saida_hi), 64'd0);
    chk("midrst zero", 64'(zero), 64'd1);
    chk("midrst ocupado", 64'(ocupado), 64'd0);
    chk("midrst pronto", 64'(pronto), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0;
    np = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (pronto || ocupado) np++;
    end
    chk("no pronto after abort", 64'(np), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
